// File: rtl/mc_riscv_controller.sv
// Multi-cycle RISC-V main control FSM driving ALU op and datapath mux selects.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes park in HALT and raise Illegal.
module mc_riscv_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUOp
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALR2, LUI, HALT
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_SLT = 3'd4, ALU_SLTU = 3'd5, ALU_XOR = 3'd6;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

  state_t state, cur;
  logic [2:0] alu_fn;
  logic       br_take;

  always_ff @(posedge clk) begin
    if (rst) state <= state_t'(RESET_STATE);
    else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_B:         state <= BRANCH;
            OP_JAL:       state <= JAL;
            OP_JALR:      state <= JALR;
            OP_LUI:       state <= LUI;
`ifdef MC_ILLEGAL_TRAP_EN
            default:      state <= HALT;
`else
            default:      state <= FETCH;
`endif
          endcase
        end
        MEMADR:  state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD: state <= MEMWB;
        EXECR, EXECI, JAL, JALR2: state <= ALUWB;
        JALR:    state <= JALR2;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // funct3 decode; only register-register ops honour funct7b5 for sub
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (state == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = Neg;
      3'b101:  br_take = ~Neg;
      default: br_take = 1'b0;
    endcase
  end

  // During reset the outputs show FETCH with all write enables suppressed
  assign cur = rst ? FETCH : state;

  always_comb begin
    PCWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
    ResultSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ImmSrc = IMM_I; ALUOp = ALU_ADD;
    case (cur)
      FETCH:    begin IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = (op == OP_JAL) ? IMM_J : IMM_B; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = (op == OP_LW) ? IMM_I : IMM_S; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      EXECR:    begin ALUSrcA = 2'b10; ALUOp = alu_fn; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = IMM_I; ALUOp = alu_fn; end
      ALUWB:    RegWrite = 1'b1;
      BRANCH:   begin ALUSrcA = 2'b10; ALUOp = ALU_SUB; PCWrite = br_take; end
      JAL, JALR2: begin PCWrite = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ImmSrc = IMM_I; end
      LUI:      begin ImmSrc = IMM_U; ResultSrc = 2'b11; RegWrite = 1'b1; end
      default:  ;
    endcase
    if (rst) begin
      PCWrite = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = (cur == HALT);
`endif

endmodule

// File: tb/tb_mc_riscv_controller.sv
// Scoreboard bench: per-instruction cycle tables model the expected control word.
module tb_mc_riscv_controller;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, alu;
    logic       ill;
  } cw_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, Zero = 1'b0, Neg = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUOp;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       Illegal;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0, failures = 0;
  cw_t exp_q[$];

  mc_riscv_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp)
`ifdef MC_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit known(input logic [6:0] o);
    return o inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37};
  endfunction

  // cycles per instruction; an unknown op under trap sits in HALT then gets reset
  function automatic int instr_len(input logic [6:0] o);
    case (o)
      7'h03, 7'h67:        return 5;
      7'h23, 7'h33, 7'h13, 7'h6f: return 4;
      7'h63, 7'h37:        return 3;
      default:             return TRAP ? 5 : 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 3'd1 : 3'd0;
      3'd2: return 3'd4;
      3'd3: return 3'd5;
      3'd4: return 3'd6;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n;
      3'd5: return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic cw_t rst_word();
    cw_t w = '0;
    w.sb = 2'b10; w.rs = 2'b10;
    return w;
  endfunction

  // expected control word for cycle k of an instruction
  function automatic cw_t exp_word(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input int k, input logic z, input logic n);
    cw_t w = '0;
    if (k == 0) begin
      w = rst_word(); w.irw = 1'b1; w.pcw = 1'b1;
      return w;
    end
    if (k == 1) begin
      w.sa = 2'b01; w.sb = 2'b01; w.imm = (o == 7'h6f) ? 3'd3 : 3'd2;
      return w;
    end
    case (o)
      7'h03: case (k)
        2: begin w.sa = 2'b10; w.sb = 2'b01; w.imm = 3'd0; end
        3: w.adr = 1'b1;
        default: begin w.rs = 2'b01; w.rw = 1'b1; end
      endcase
      7'h23: if (k == 2) begin w.sa = 2'b10; w.sb = 2'b01; w.imm = 3'd1; end
             else begin w.adr = 1'b1; w.mw = 1'b1; end
      7'h33: if (k == 2) begin w.sa = 2'b10; w.alu = alu_of(f3, f7, 1'b1); end
             else w.rw = 1'b1;
      7'h13: if (k == 2) begin w.sa = 2'b10; w.sb = 2'b01; w.alu = alu_of(f3, f7, 1'b0); end
             else w.rw = 1'b1;
      7'h63: begin w.sa = 2'b10; w.alu = 3'd1; w.pcw = taken(f3, z, n); end
      7'h6f: if (k == 2) begin w.pcw = 1'b1; w.sa = 2'b01; w.sb = 2'b10; end
             else w.rw = 1'b1;
      7'h67: case (k)
        2: begin w.sa = 2'b10; w.sb = 2'b01; end
        3: begin w.pcw = 1'b1; w.sa = 2'b01; w.sb = 2'b10; end
        default: w.rw = 1'b1;
      endcase
      7'h37: begin w.imm = 3'd4; w.rs = 2'b11; w.rw = 1'b1; end
      default: w.ill = 1'b1;
    endcase
    return w;
  endfunction

  // zf/nf < 0 means random flag each cycle; rst_at < 0 means no reset
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int rst_at, input int zf, input int nf);
    int len = instr_len(o);
    int ra = rst_at;
    if (TRAP && !known(o) && (ra < 0 || ra > 4)) ra = 4;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      op = o; funct3 = f3; funct7b5 = f7;
      Zero = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
      Neg  = (nf < 0) ? 1'($urandom_range(0, 1)) : nf[0];
      rst = (k == ra);
      if (rst) begin
        exp_q.push_back(rst_word());
        break;
      end
      exp_q.push_back(exp_word(o, f3, f7, k, Zero, Neg));
    end
  endtask

  // monitor: every negedge the DUT presents a control word; compare against queue head
  initial begin
    cw_t got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUOp,
`ifdef MC_ILLEGAL_TRAP_EN
                Illegal};
`else
                1'b0};
`endif
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL ctrl_word t=%0t op=%h f3=%0d got=%h want=%h", $time, op, funct3, got, want);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37};
    // reset state, two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.push_back(rst_word());
    end
    run_instr(7'h33, 3'd0, 1'b1, -1, -1, -1);  // sub
    run_instr(7'h03, 3'd2, 1'b0, -1, -1, -1);  // lw
    run_instr(7'h63, 3'd0, 1'b0, -1, 1, 0);    // beq taken
    run_instr(7'h63, 3'd0, 1'b0, -1, 0, 0);    // beq not taken
    run_instr(7'h63, 3'd4, 1'b0, -1, 0, 1);    // blt taken
    run_instr(7'h63, 3'd5, 1'b0, -1, 0, 1);    // bge not taken
    run_instr(7'h23, 3'd2, 1'b0, 3, -1, -1);   // reset during MEMWRITE
    run_instr(7'h13, 3'd0, 1'b1, -1, -1, -1);  // addi ignores funct7b5
    run_instr(7'h7f, 3'd0, 1'b0, -1, -1, -1);  // unknown op
    run_instr(7'h6f, 3'd0, 1'b0, -1, -1, -1);
    run_instr(7'h67, 3'd0, 1'b0, -1, -1, -1);
    run_instr(7'h37, 3'd0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 300; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(o, 3'($urandom), 1'($urandom),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1, -1, -1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
